// File: rtl/frame_pingpong_sched_if.sv
// rtl/frame_pingpong_sched_if.sv - camera/reshaper/RAM signal bundle for the ping-pong frame scheduler
interface frame_pingpong_sched_if #(
  parameter int ADDR_W = 20
);
  logic              cam_frame_done;
  logic              cam_bank;
  logic [ADDR_W-1:0] cam_base;
  logic              rs_ena;
  logic [ADDR_W-1:0] rs_rd_addr;
  logic [ADDR_W-1:0] mem_rd_addr;
  logic              rs_wr_en;
  logic              busy;
  logic              frame_out;
  logic              frame_drop;
  logic [15:0]       frames_done;
  logic              err_timeout;

  modport master (
    output cam_frame_done, rs_rd_addr, rs_wr_en,
    input  cam_bank, cam_base, rs_ena, mem_rd_addr, busy,
           frame_out, frame_drop, frames_done, err_timeout
  );

  modport slave (
    input  cam_frame_done, rs_rd_addr, rs_wr_en,
    output cam_bank, cam_base, rs_ena, mem_rd_addr, busy,
           frame_out, frame_drop, frames_done, err_timeout
  );
endinterface

// File: rtl/frame_pingpong_sched.sv
// rtl/frame_pingpong_sched.sv - ping-pong bank scheduler: camera handoff, reshaper start, beat counting, watchdog
module frame_pingpong_sched #(
  parameter int ADDR_W      = 20,
  parameter int FRAME_WORDS = 76800,
  parameter int OUT_WORDS   = 230400,
  parameter int ENA_LEN     = 6,
  parameter int TIMEOUT     = 65535
) (
  input logic                    clk,
  input logic                    rstn,
  frame_pingpong_sched_if.slave  bus
);
  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_START = 3'd1;
  localparam logic [2:0] S_RUN   = 3'd2;
  localparam logic [2:0] S_DONE  = 3'd3;
  localparam logic [2:0] S_ABORT = 3'd4;

  localparam int BEAT_W = ($clog2(OUT_WORDS) > 0) ? $clog2(OUT_WORDS) : 1;
  localparam int WD_W   = $clog2(TIMEOUT + 1);
  localparam int ENA_W  = $clog2(ENA_LEN + 1);
  localparam logic [ADDR_W-1:0] BANK1_BASE = ADDR_W'(FRAME_WORDS);

  logic [2:0]        state;
  logic [1:0]        full;
  logic [1:0]        full_next;
  logic              cam_bank;
  logic              rs_bank;
  logic [BEAT_W-1:0] beat_cnt;
  logic [WD_W-1:0]   wd_cnt;
  logic [ENA_W-1:0]  ena_cnt;
  logic [15:0]       frames_done;
  logic              frame_drop;
  logic              err_timeout;
  logic              releasing;
  logic              accept;

  // A bank being released this cycle counts as free, so a handoff racing DONE/ABORT is kept.
  assign releasing = (state == S_DONE) || (state == S_ABORT);
  assign accept    = !full[~cam_bank] || (releasing && (rs_bank == ~cam_bank));

  always_comb begin
    full_next = full;
    if (releasing)
      full_next[rs_bank] = 1'b0;
    if (bus.cam_frame_done && accept)
      full_next[cam_bank] = 1'b1;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state       <= S_IDLE;
      full        <= '0;
      cam_bank    <= 1'b0;
      rs_bank     <= 1'b0;
      beat_cnt    <= '0;
      wd_cnt      <= '0;
      ena_cnt     <= '0;
      frames_done <= '0;
      frame_drop  <= 1'b0;
      err_timeout <= 1'b0;
    end else begin
      full       <= full_next;
      frame_drop <= bus.cam_frame_done && !accept;
      if (bus.cam_frame_done && accept)
        cam_bank <= ~cam_bank;

      case (state)
        S_IDLE: begin
          if (|full) begin
            rs_bank  <= full[1];
            beat_cnt <= '0;
            wd_cnt   <= '0;
            ena_cnt  <= '0;
            state    <= S_START;
          end
        end
        S_START: begin
          if (bus.rs_wr_en)
            beat_cnt <= beat_cnt + BEAT_W'(1);
          wd_cnt  <= '0;
          ena_cnt <= ena_cnt + ENA_W'(1);
          if (ena_cnt == ENA_W'(ENA_LEN - 1))
            state <= S_RUN;
        end
        S_RUN: begin
          if (bus.rs_wr_en) begin
            beat_cnt <= beat_cnt + BEAT_W'(1);
            wd_cnt   <= '0;
            if (beat_cnt == BEAT_W'(OUT_WORDS - 1))
              state <= S_DONE;
          end else if (wd_cnt == WD_W'(TIMEOUT)) begin
            state <= S_ABORT;
          end else begin
            wd_cnt <= wd_cnt + WD_W'(1);
          end
        end
        S_DONE: begin
          frames_done <= frames_done + 16'd1;
          state       <= S_IDLE;
        end
        S_ABORT: begin
          err_timeout <= 1'b1;
          state       <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign bus.cam_bank    = cam_bank;
  assign bus.cam_base    = cam_bank ? BANK1_BASE : '0;
  assign bus.mem_rd_addr = bus.rs_rd_addr + (rs_bank ? BANK1_BASE : '0);
  assign bus.rs_ena      = (state == S_START);
  assign bus.busy        = (state != S_IDLE);
  assign bus.frame_out   = (state == S_DONE);
  assign bus.frame_drop  = frame_drop;
  assign bus.frames_done = frames_done;
  assign bus.err_timeout = err_timeout;
endmodule

// File: tb/tb_frame_pingpong_sched.sv
// tb/tb_frame_pingpong_sched.sv - self-checking bench for frame_pingpong_sched against a frame-level reference model
module tb_frame_pingpong_sched;
  localparam int AW = 20;
  localparam int FW = 16;
  localparam int OW = 48;
  localparam int EL = 6;
  localparam int TO = 100;

  logic clk = 1'b0;
  logic rstn = 1'b0;
  always #5 clk = ~clk;

  frame_pingpong_sched_if #(.ADDR_W(AW)) bus();

  frame_pingpong_sched #(
    .ADDR_W(AW), .FRAME_WORDS(FW), .OUT_WORDS(OW), .ENA_LEN(EL), .TIMEOUT(TO)
  ) dut (
    .clk(clk), .rstn(rstn), .bus(bus)
  );

  typedef struct packed {
    logic          cam_bank;
    logic [AW-1:0] cam_base;
    logic          rs_ena;
    logic [AW-1:0] mem_rd_addr;
    logic          busy;
    logic          frame_out;
    logic          frame_drop;
    logic [15:0]   frames_done;
    logic          err_timeout;
  } obs_t;

  typedef struct {
    bit            cfd;
    bit            wr;
    logic [AW-1:0] rd;
    bit            cam_bank;
    bit            ena;
    bit            busy;
    logic [AW-1:0] mem;
  } vec_t;

  int tests = 0;
  int fails = 0;

  // Reference model: frame-level bookkeeping of banks, launch age, beats and idle time.
  bit       m_cam;
  bit [1:0] m_full;
  bit       m_active;
  int       m_age;
  int       m_beats;
  int       m_idle;
  int       m_finish;   // 0 none, 1 frame completed this cycle, 2 aborted this cycle
  bit       m_rbank;
  bit       m_drop;
  int       m_frames;
  bit       m_err;

  task automatic model_reset();
    m_cam = 0; m_full = '0; m_active = 0; m_age = 0; m_beats = 0; m_idle = 0;
    m_finish = 0; m_rbank = 0; m_drop = 0; m_frames = 0; m_err = 0;
  endtask

  task automatic model_step(input bit cfd, input bit wr);
    bit       rel;
    bit       acc;
    bit [1:0] f;
    rel = (m_finish != 0);
    acc = cfd && (!m_full[~m_cam] || (rel && (m_rbank == ~m_cam)));
    f = m_full;
    if (rel) f[m_rbank] = 1'b0;
    if (acc) f[m_cam] = 1'b1;
    m_drop = cfd && !acc;
    if (m_finish == 1) m_frames++;
    if (m_finish == 2) m_err = 1;
    if (m_finish != 0) begin
      m_finish = 0;
    end else if (m_active) begin
      if (m_age < EL) begin
        if (wr) m_beats++;
        m_idle = 0;
        m_age++;
      end else if (wr) begin
        if (m_beats == OW - 1) begin m_active = 0; m_finish = 1; end
        m_beats++;
        m_idle = 0;
      end else if (m_idle == TO) begin
        m_active = 0; m_finish = 2;
      end else begin
        m_idle++;
      end
    end else if (m_full != 0) begin
      m_active = 1; m_age = 0; m_beats = 0; m_idle = 0; m_rbank = m_full[1];
    end
    m_full = f;
    if (acc) m_cam = ~m_cam;
  endtask

  function automatic obs_t model_obs(input logic [AW-1:0] rd);
    obs_t o;
    o.cam_bank    = m_cam;
    o.cam_base    = m_cam ? AW'(FW) : '0;
    o.rs_ena      = m_active && (m_age < EL);
    o.mem_rd_addr = rd + (m_rbank ? AW'(FW) : '0);
    o.busy        = m_active || (m_finish != 0);
    o.frame_out   = (m_finish == 1);
    o.frame_drop  = m_drop;
    o.frames_done = m_frames[15:0];
    o.err_timeout = m_err;
    return o;
  endfunction

  function automatic obs_t dut_obs();
    obs_t o;
    o.cam_bank    = bus.cam_bank;
    o.cam_base    = bus.cam_base;
    o.rs_ena      = bus.rs_ena;
    o.mem_rd_addr = bus.mem_rd_addr;
    o.busy        = bus.busy;
    o.frame_out   = bus.frame_out;
    o.frame_drop  = bus.frame_drop;
    o.frames_done = bus.frames_done;
    o.err_timeout = bus.err_timeout;
    return o;
  endfunction

  task automatic check_obs(input string name, input obs_t got, input obs_t exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s @%0t: got bank=%0d base=%0d ena=%0d mem=%0d busy=%0d fo=%0d fd=%0d n=%0d err=%0d, expected bank=%0d base=%0d ena=%0d mem=%0d busy=%0d fo=%0d fd=%0d n=%0d err=%0d",
               name, $time, got.cam_bank, got.cam_base, got.rs_ena, got.mem_rd_addr, got.busy,
               got.frame_out, got.frame_drop, got.frames_done, got.err_timeout,
               exp.cam_bank, exp.cam_base, exp.rs_ena, exp.mem_rd_addr, exp.busy,
               exp.frame_out, exp.frame_drop, exp.frames_done, exp.err_timeout);
    end
  endtask

  task automatic check_val(input string name, input int got, input int exp);
    tests++;
    if (got != exp) begin
      fails++;
      $display("FAIL %s @%0t: got %0d, expected %0d", name, $time, got, exp);
    end
  endtask

  // Called just after a rising edge: drive inputs, sample at the falling edge, check against the model.
  task automatic drive_and_sample(input bit cfd, input bit wr, input logic [AW-1:0] rd, output obs_t got);
    bus.cam_frame_done = cfd;
    bus.rs_wr_en       = wr;
    bus.rs_rd_addr     = rd;
    @(negedge clk);
    got = dut_obs();
    check_obs("model", got, model_obs(rd));
  endtask

  task automatic finish_cycle(input bit cfd, input bit wr);
    @(posedge clk);
    model_step(cfd, wr);
    #1;
  endtask

  task automatic cycle(input bit cfd, input bit wr, input logic [AW-1:0] rd);
    obs_t got;
    drive_and_sample(cfd, wr, rd, got);
    finish_cycle(cfd, wr);
  endtask

  vec_t tbl[9];
  obs_t got;
  int   sent;
  int   n;
  bit   seen;
  int   ena_seen;
  int   stall;
  bit   cfd_r;
  bit   wr_r;

  initial begin
    tbl[0] = '{1, 0, 5, 0, 0, 0, 5};
    tbl[1] = '{0, 0, 5, 1, 0, 0, 5};
    for (int i = 2; i < 8; i++) tbl[i] = '{0, 0, 5, 1, 1, 1, 5};
    tbl[8] = '{0, 0, 5, 1, 0, 1, 5};

    bus.cam_frame_done = 0; bus.rs_wr_en = 0; bus.rs_rd_addr = '0;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    check_val("reset_cam_bank", bus.cam_bank, 0);
    check_val("reset_rs_ena", bus.rs_ena, 0);
    check_val("reset_busy", bus.busy, 0);
    check_val("reset_frames_done", bus.frames_done, 0);
    check_val("reset_err_timeout", bus.err_timeout, 0);
    rstn = 1;

    // Single frame: start sequence from the table, then 48 beats.
    for (int i = 0; i < 9; i++) begin
      drive_and_sample(tbl[i].cfd, tbl[i].wr, tbl[i].rd, got);
      check_val($sformatf("tbl%0d_cam_bank", i), got.cam_bank, tbl[i].cam_bank);
      check_val($sformatf("tbl%0d_rs_ena", i), got.rs_ena, tbl[i].ena);
      check_val($sformatf("tbl%0d_busy", i), got.busy, tbl[i].busy);
      check_val($sformatf("tbl%0d_mem_rd_addr", i), got.mem_rd_addr, tbl[i].mem);
      finish_cycle(tbl[i].cfd, tbl[i].wr);
    end
    for (int i = 0; i < OW; i++) cycle(0, 1, 5);
    drive_and_sample(0, 0, 5, got);
    check_val("single_frame_out", got.frame_out, 1);
    finish_cycle(0, 0);
    drive_and_sample(0, 0, 5, got);
    check_val("single_frames_done", got.frames_done, 1);
    check_val("single_busy_after", got.busy, 0);
    finish_cycle(0, 0);

    // Bank offset: camera on bank 1 hands off, reshaper reads bank 1.
    cycle(1, 0, 5);
    cycle(0, 0, 5);
    drive_and_sample(0, 0, 5, got);
    check_val("offset_mem_rd_addr", got.mem_rd_addr, 21);
    check_val("offset_cam_base", got.cam_base, 0);
    check_val("offset_rs_ena", got.rs_ena, 1);
    finish_cycle(0, 0);
    for (int i = 1; i < EL; i++) cycle(0, 0, 5);

    // Drop: camera frames arrive while the other bank is still being reshaped.
    sent = 0;
    for (int i = 0; i < 10; i++) begin cycle(0, 1, 5); sent++; end
    cycle(1, 1, 5); sent++;
    cycle(0, 1, 5); sent++;
    cycle(1, 1, 5); sent++;
    drive_and_sample(0, 1, 5, got);
    check_val("drop_frame_drop", got.frame_drop, 1);
    check_val("drop_cam_bank", got.cam_bank, 0);
    finish_cycle(0, 1); sent++;
    while (sent < OW) begin cycle(0, 1, 5); sent++; end

    // Simultaneous release: handoff lands in the DONE cycle.
    drive_and_sample(1, 0, 3, got);
    check_val("simul_frame_out", got.frame_out, 1);
    finish_cycle(1, 0);
    drive_and_sample(0, 0, 3, got);
    check_val("simul_no_drop", got.frame_drop, 0);
    check_val("simul_cam_bank", got.cam_bank, 1);
    finish_cycle(0, 0);
    drive_and_sample(0, 0, 3, got);
    check_val("simul_next_bank_addr", got.mem_rd_addr, 3);
    check_val("simul_next_rs_ena", got.rs_ena, 1);
    finish_cycle(0, 0);
    for (int i = 1; i < EL; i++) cycle(0, 0, 3);

    // Timeout: 20 beats, then silence.
    for (int i = 0; i < 20; i++) cycle(0, 1, 3);
    n = 0; seen = 0;
    for (int i = 0; i < 300; i++) begin
      drive_and_sample(0, 0, 3, got);
      finish_cycle(0, 0);
      n++;
      if (got.frame_out) seen = 1;
      if (got.err_timeout) break;
    end
    check_val("timeout_err", got.err_timeout, 1);
    check_val("timeout_latency", n, TO + 3);
    check_val("timeout_no_frame_out", seen, 0);
    check_val("timeout_frames_done", got.frames_done, 2);

    // A following frame still completes.
    cycle(1, 0, 0);
    seen = 0;
    for (int i = 0; i < 100; i++) begin
      drive_and_sample(0, 1, AW'($urandom_range(0, FW - 1)), got);
      finish_cycle(0, 1);
      if (got.frame_out) begin seen = 1; break; end
    end
    check_val("after_timeout_frame_out", seen, 1);
    drive_and_sample(0, 0, 0, got);
    check_val("after_timeout_frames_done", got.frames_done, 3);
    finish_cycle(0, 0);

    // Reset mid-RUN at beat 30.
    cycle(1, 0, 0);
    for (int i = 0; i < EL + 1; i++) cycle(0, 0, 0);
    for (int i = 0; i < 30; i++) cycle(0, 1, 0);
    rstn = 0;
    bus.rs_wr_en = 0;
    #1;
    check_val("rst_rs_ena", bus.rs_ena, 0);
    check_val("rst_busy", bus.busy, 0);
    check_val("rst_frame_out", bus.frame_out, 0);
    check_val("rst_frame_drop", bus.frame_drop, 0);
    check_val("rst_err_timeout", bus.err_timeout, 0);
    check_val("rst_frames_done", bus.frames_done, 0);
    check_val("rst_cam_bank", bus.cam_bank, 0);
    model_reset();
    @(posedge clk);
    #1;
    rstn = 1;
    ena_seen = 0;
    for (int i = 0; i < 20; i++) begin
      wr_r = 1'($urandom_range(0, 1));
      drive_and_sample(0, wr_r, AW'($urandom_range(0, FW - 1)), got);
      if (got.rs_ena) ena_seen++;
      finish_cycle(0, wr_r);
    end
    check_val("rst_no_ena_after_release", ena_seen, 0);

    // Randomized traffic with occasional long stalls.
    stall = 0;
    for (int i = 0; i < 6000; i++) begin
      cfd_r = ($urandom_range(0, 59) == 0);
      if (stall > 0) begin
        wr_r = 0;
        stall--;
      end else begin
        wr_r = ($urandom_range(0, 3) != 0);
        if ($urandom_range(0, 399) == 0) stall = $urandom_range(90, 130);
      end
      cycle(cfd_r, wr_r, AW'($urandom_range(0, FW - 1)));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
